// File: rtl/cache_tag_array_nway.sv
// Set-associative tag store: WAYS single-port tag banks sharing one set index.
// Lookup latency 1 (accept in N, response in N+1); fill writes one way; a flush clears every tag.
// Backpressure: a stalled response is held and blocks new lookups; fill beats lookup; flush blocks both.
//
// Optional macro TAG_ARRAY_HOLD_FWD_EN: fills and flush writes that hit the index
// of a held response are forwarded into it, so a stalled response never goes stale.
//
// Ports:
//   clock, reset                  rising-edge clock, async active-low reset
//   lkp_valid/lkp_index/lkp_accept  lookup request (valid/accept)
//   rsp_valid/rsp_data/rsp_ready    lookup response, way k at [k*TAG_W +: TAG_W]
//   fill_valid/fill_index/fill_way/fill_wdata/fill_ready  single-way tag write
//   flush_req/flush_busy/flush_done  invalidate-all sequencer
module cache_tag_array_nway #(
   parameter int WAYS  = 8,
   parameter int SETS  = 64,
   parameter int TAG_W = 44,
   parameter int IDX_W = $clog2(SETS),
   parameter int WAY_W = $clog2(WAYS)
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    lkp_valid,
   input  logic [IDX_W-1:0]        lkp_index,
   output logic                    lkp_accept,
   output logic                    rsp_valid,
   output logic [WAYS*TAG_W-1:0]   rsp_data,
   input  logic                    rsp_ready,
   input  logic                    fill_valid,
   input  logic [IDX_W-1:0]        fill_index,
   input  logic [WAY_W-1:0]        fill_way,
   input  logic [TAG_W-1:0]        fill_wdata,
   output logic                    fill_ready,
   input  logic                    flush_req,
   output logic                    flush_busy,
   output logic                    flush_done
);

   typedef enum logic [0:0] {ST_IDLE, ST_FLUSH} state_t;

   state_t             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic               done_q, done_d;

   logic [TAG_W-1:0]      mem     [WAYS][SETS];
   logic [TAG_W-1:0]      bank_rd [WAYS];
   logic [WAYS*TAG_W-1:0] bank_cat;
   logic [WAYS*TAG_W-1:0] hold_q, hold_d, hold_src;
   logic                  rsp_vld_q, held_q;
   logic                  flushing, fill_fire, lkp_fire;

   assign flushing   = (state_q == ST_FLUSH);
   assign flush_busy = flushing;
   assign flush_done = done_q;
   assign fill_ready = !flushing;
   assign fill_fire  = fill_valid && fill_ready;
   assign lkp_accept = lkp_valid && !fill_valid && !flushing && (!rsp_vld_q || rsp_ready);
   assign lkp_fire   = lkp_accept;

   // ---------------- flush sequencer ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (flush_req) begin
               state_d = ST_FLUSH;
               cnt_d   = '0;
            end
         end
         ST_FLUSH: begin
            cnt_d = cnt_q + 1'b1;
            // Last set is written this cycle; done pulses in the following cycle.
            if (cnt_q == IDX_W'(SETS - 1)) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // ---------------- tag banks ----------------
   // Contents are deliberately not reset; a flush is required after power-up.
   // Each bank does at most one access per cycle: flush write, its own fill, or a lookup read.
   always_ff @(posedge clock) begin
      for (int w = 0; w < WAYS; w++) begin
         if (flushing)
            mem[w][cnt_q] <= '0;
         else if (fill_fire && (fill_way == WAY_W'(w)))
            mem[w][fill_index] <= fill_wdata;
         else if (lkp_fire)
            bank_rd[w] <= mem[w][lkp_index];
      end
   end

   always_comb begin
      bank_cat = '0;
      for (int w = 0; w < WAYS; w++)
         bank_cat[w*TAG_W +: TAG_W] = bank_rd[w];
   end

   // ---------------- response path ----------------
   // The first response cycle is served straight from the bank outputs; a stall
   // captures them so rsp_data stays stable until the handshake.
   assign hold_src = held_q ? hold_q : bank_cat;

`ifdef TAG_ARRAY_HOLD_FWD_EN
   logic [IDX_W-1:0] rsp_idx_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         rsp_idx_q <= '0;
      else if (lkp_fire)
         rsp_idx_q <= lkp_index;
   end

   // Fill and flush are mutually exclusive (fill_ready is low while flushing).
   always_comb begin
      hold_d = hold_src;
      if (flushing && (cnt_q == rsp_idx_q))
         hold_d = '0;
      else if (fill_fire && (fill_index == rsp_idx_q))
         hold_d[fill_way*TAG_W +: TAG_W] = fill_wdata;
   end
`else
   always_comb begin
      hold_d = hold_src;
   end
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rsp_vld_q <= 1'b0;
         held_q    <= 1'b0;
         hold_q    <= '0;
      end else if (lkp_fire) begin
         rsp_vld_q <= 1'b1;
         held_q    <= 1'b0;
      end else if (rsp_vld_q && rsp_ready) begin
         rsp_vld_q <= 1'b0;
         held_q    <= 1'b0;
      end else if (rsp_vld_q) begin
         held_q    <= 1'b1;
         hold_q    <= hold_d;
      end
   end

   assign rsp_valid = rsp_vld_q;
   assign rsp_data  = (rsp_vld_q && !held_q) ? bank_cat : hold_q;

endmodule

// File: doc/cache_tag_array_nway.md
Name: cache_tag_array_nway

Overview:
- Parametrised set-associative tag store for the L1 caches: WAYS single-port tag banks of SETS entries each, all sharing one index.
- Serves lookup reads through a valid/accept request and a valid/ready response, and fill writes to one selected way.
- Adds a hardware flush sequencer that clears every tag.
- Sits between the cache lookup stage and the refill engine.

Parameters:
WAYS, 8, number of ways/banks (power of two, >=2)
SETS, 64, entries per bank (power of two, >=2)
TAG_W, 44, stored tag entry width (tag plus status bits)
IDX_W, $clog2(SETS), index width (derived)
WAY_W, $clog2(WAYS), way-select width (derived)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-low reset
lkp_valid  in  1  lookup request
lkp_index  in  IDX_W  lookup set index
lkp_accept  out  1  lookup taken this cycle
rsp_valid  out  1  response holds a read result
rsp_data  out  WAYS*TAG_W  all ways of the set; way k occupies bits [k*TAG_W +: TAG_W]
rsp_ready  in  1  consumer takes the response
fill_valid  in  1  tag write request
fill_index  in  IDX_W  write set
fill_way  in  WAY_W  target way
fill_wdata  in  TAG_W  new tag entry
fill_ready  out  1  write taken this cycle
flush_req  in  1  start invalidate-all (single-cycle pulse)
flush_busy  out  1  flush in progress
flush_done  out  1  one-cycle pulse after the last set is cleared

Behaviour:
- Reset (reset=0, async): FSM returns to IDLE; flush counter=0; rsp_valid=0; rsp_data hold register=0; flush_busy=0; flush_done=0.
- Tag contents are NOT reset. Software or the controller must issue a flush.
- FSM states:
  - IDLE: flush_req=1 -> FLUSH, counter=0.
  - FLUSH: each cycle writes 0 to entry [counter] of all WAYS banks, then counter++.
  - When counter==SETS-1 and that write completes -> IDLE, with flush_done=1 for exactly one cycle.
  - A flush therefore takes exactly SETS cycles.
  - flush_req while in FLUSH is ignored.
- flush_busy = (state==FLUSH).
- fill_ready = !flush_busy. A fill write occurs when fill_valid && fill_ready, to bank fill_way only (exactly one bank write-enabled).
- Arbitration: fill has priority over lookup. lkp_accept = lkp_valid && !fill_valid && !flush_busy && (!rsp_valid || rsp_ready).
- Bank enable: a bank is enabled only on an accepted lookup, its own fill, or flush. An unselected bank must never be written.
- Lookup latency is 1:
  - Accept in cycle N -> rsp_valid=1 in cycle N+1, with rsp_data driven directly from bank outputs.
  - If rsp_ready=0 in N+1, the bank outputs are captured into the hold register at that edge. rsp_data then comes from the hold register, stable until handshake.
  - rsp_valid clears on rsp_valid && rsp_ready unless a new lookup is accepted in the same cycle (back-to-back accepts give one response per cycle).
- The hold register also records the response index, used by the optional feature.
- Reset asserted mid-flush: flush aborts and is not resumed; tags are partially cleared.
- Reset asserted with a pending response: the response is dropped.
- A lookup and a fill to the same index in the same cycle: fill wins; the lookup is retried by the requester and reads the new value.

Optional Feature:
- Macro: TAG_ARRAY_HOLD_FWD_EN
- Defined: while rsp_valid=1 and the response is held (stalled), a fill write with fill_index equal to the held index replaces way fill_way of the held rsp_data with fill_wdata in the same edge. A flush write to the held index zeroes the whole held response. The held response is therefore never stale.
- Undefined: the held response reflects array contents at read time; no forwarding logic is synthesised.

Test Plan:
- Reset, then flush_req -> flush_busy=1 for exactly 64 cycles, flush_done pulses once. Lookup of index 0x3F returns rsp_data all zero; lkp_accept=0 throughout the flush.
- Fill idx 5 way 3 data 0xABC, then lookup idx 5 -> next cycle rsp_valid=1, way-3 field=0xABC, other ways 0; no other bank written.
- fill_valid and lkp_valid in the same cycle (idx 9) -> fill_ready=1, lkp_accept=0. The next-cycle lookup returns the filled value.
- Lookup idx 2 with rsp_ready=0 for 5 cycles -> rsp_data constant and lkp_accept=0 for a new request. With rsp_ready=1, back-to-back lookups give 1 response/cycle.
- With TAG_ARRAY_HOLD_FWD_EN: hold response idx 7, fill idx 7 way 0 data 0x55 -> held way-0 field becomes 0x55 next cycle. Without the macro it is unchanged.
- Reset pulse at flush cycle 20 -> flush_busy=0 immediately, no flush_done; a new flush_req restarts at counter 0.
